// File: rtl/alu_reservation_station_pkg.sv
// Shared constants for the ALU reservation station: widths, sizes and the
// RV32I opcode / funct3 codes carried by each entry.
package alu_reservation_station_pkg;

    localparam int unsigned DATA_WID    = 32;
    localparam int unsigned ADDR_WID    = 32;
    localparam int unsigned ROB_POS_WID = 4;
    localparam int unsigned RS_SIZE     = 16;
    localparam int unsigned OPCODE_WID  = 7;
    localparam int unsigned FUNCT3_WID  = 3;

    localparam logic [OPCODE_WID-1:0] OPCODE_ARITH  = 7'b0110011;
    localparam logic [OPCODE_WID-1:0] OPCODE_ARITHI = 7'b0010011;
    localparam logic [OPCODE_WID-1:0] OPCODE_BR     = 7'b1100011;
    localparam logic [OPCODE_WID-1:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [OPCODE_WID-1:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [OPCODE_WID-1:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [OPCODE_WID-1:0] OPCODE_AUIPC  = 7'b0010111;

    localparam logic [FUNCT3_WID-1:0] FUNCT3_ADD  = 3'b000;
    localparam logic [FUNCT3_WID-1:0] FUNCT3_SLL  = 3'b001;
    localparam logic [FUNCT3_WID-1:0] FUNCT3_SLT  = 3'b010;
    localparam logic [FUNCT3_WID-1:0] FUNCT3_SLTU = 3'b011;
    localparam logic [FUNCT3_WID-1:0] FUNCT3_XOR  = 3'b100;
    localparam logic [FUNCT3_WID-1:0] FUNCT3_SRL  = 3'b101;
    localparam logic [FUNCT3_WID-1:0] FUNCT3_OR   = 3'b110;
    localparam logic [FUNCT3_WID-1:0] FUNCT3_AND  = 3'b111;
    localparam logic [FUNCT3_WID-1:0] FUNCT3_BEQ  = 3'b000;
    localparam logic [FUNCT3_WID-1:0] FUNCT3_BNE  = 3'b001;
    localparam logic [FUNCT3_WID-1:0] FUNCT3_BLT  = 3'b100;
    localparam logic [FUNCT3_WID-1:0] FUNCT3_BGE  = 3'b101;
    localparam logic [FUNCT3_WID-1:0] FUNCT3_BLTU = 3'b110;
    localparam logic [FUNCT3_WID-1:0] FUNCT3_BGEU = 3'b111;

endpackage

// File: rtl/alu_reservation_station_prio_enc.sv
// Lowest-set-bit encoder: reports whether any request bit is set and the
// index of the lowest one. Purely combinational.
module rs_prio_enc #(
    parameter int unsigned N     = 16,
    parameter int unsigned IDX_W = 4
)(
    input  logic [N-1:0]     i_req,
    output logic             o_found_c,
    output logic [IDX_W-1:0] o_idx_c
);

    always_comb begin
        o_found_c = 1'b0;
        o_idx_c   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!o_found_c && i_req[i]) begin
                o_found_c = 1'b1;
                o_idx_c   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers ALU-class instructions until both operands
// are known, snoops ALU/LSB broadcasts, and dispatches one ready entry per cycle.
module alu_reservation_station #(
    parameter int unsigned RS_SIZE   = alu_reservation_station_pkg::RS_SIZE,
    parameter int unsigned ROB_POS_W = alu_reservation_station_pkg::ROB_POS_WID
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy,
    input  logic                 rollback,
    input  logic                 issue,
    input  logic [ROB_POS_W-1:0] issue_rob_pos,
    input  logic [6:0]           issue_opcode,
    input  logic [2:0]           issue_funct3,
    input  logic                 issue_funct7,
    input  logic [31:0]          issue_val1,
    input  logic                 issue_has_dep1,
    input  logic [ROB_POS_W-1:0] issue_dep1,
    input  logic [31:0]          issue_val2,
    input  logic                 issue_has_dep2,
    input  logic [ROB_POS_W-1:0] issue_dep2,
    input  logic [31:0]          issue_imm,
    input  logic [31:0]          issue_pc,
    output logic                 rs_full,
    input  logic                 alu_res,
    input  logic [ROB_POS_W-1:0] alu_res_rob_pos,
    input  logic [31:0]          alu_res_val,
    input  logic                 lsb_res,
    input  logic [ROB_POS_W-1:0] lsb_res_rob_pos,
    input  logic [31:0]          lsb_res_val,
    output logic                 alu_en,
    output logic [6:0]           alu_opcode,
    output logic [2:0]           alu_funct3,
    output logic                 alu_funct7,
    output logic [31:0]          alu_val1,
    output logic [31:0]          alu_val2,
    output logic [31:0]          alu_imm,
    output logic [31:0]          alu_pc,
    output logic [ROB_POS_W-1:0] alu_rob_pos
);

    import alu_reservation_station_pkg::*;

    localparam int unsigned IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    // Entry storage, one flat array per field
    logic [RS_SIZE-1:0]    r_busy;
    logic [RS_SIZE-1:0]    r_pend1;
    logic [RS_SIZE-1:0]    r_pend2;
    logic [OPCODE_WID-1:0] r_opcode  [RS_SIZE];
    logic [FUNCT3_WID-1:0] r_funct3  [RS_SIZE];
    logic                  r_funct7  [RS_SIZE];
    logic [DATA_WID-1:0]   r_val1    [RS_SIZE];
    logic [DATA_WID-1:0]   r_val2    [RS_SIZE];
    logic [ROB_POS_W-1:0]  r_tag1    [RS_SIZE];
    logic [ROB_POS_W-1:0]  r_tag2    [RS_SIZE];
    logic [DATA_WID-1:0]   r_imm     [RS_SIZE];
    logic [ADDR_WID-1:0]   r_pc      [RS_SIZE];
    logic [ROB_POS_W-1:0]  r_rob_pos [RS_SIZE];

    logic                  r_full;
    logic                  r_alu_en;
    logic [OPCODE_WID-1:0] r_alu_opcode;
    logic [FUNCT3_WID-1:0] r_alu_funct3;
    logic                  r_alu_funct7;
    logic [DATA_WID-1:0]   r_alu_val1;
    logic [DATA_WID-1:0]   r_alu_val2;
    logic [DATA_WID-1:0]   r_alu_imm;
    logic [ADDR_WID-1:0]   r_alu_pc;
    logic [ROB_POS_W-1:0]  r_alu_rob_pos;

    logic [RS_SIZE-1:0]    w_ready;
    logic [RS_SIZE-1:0]    w_busy_nxt;
    logic                  w_free_found;
    logic [IDX_W-1:0]      w_free_idx;
    logic                  w_sel_found;
    logic [IDX_W-1:0]      w_sel_idx;
    logic [IDX_W-1:0]      w_ins_idx;
    logic                  w_do_ins;
    logic [DATA_WID-1:0]   w_ins_val1;
    logic [DATA_WID-1:0]   w_ins_val2;
    logic                  w_ins_pend1;
    logic                  w_ins_pend2;

    assign w_ready = r_busy & ~r_pend1 & ~r_pend2;

    rs_prio_enc #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_enc (
        .i_req     (~r_busy),
        .o_found_c (w_free_found),
        .o_idx_c   (w_free_idx)
    );

    rs_prio_enc #(.N(RS_SIZE), .IDX_W(IDX_W)) u_ready_enc (
        .i_req     (w_ready),
        .o_found_c (w_sel_found),
        .o_idx_c   (w_sel_idx)
    );

    // Reuse the dispatching slot only when it sits below every already-free slot
    assign w_ins_idx = (w_sel_found && (!w_free_found || (w_sel_idx < w_free_idx)))
                       ? w_sel_idx : w_free_idx;
    assign w_do_ins  = issue && w_free_found;

    // Insert bypass: a dependency resolved on this cycle's broadcast, ALU first
    always_comb begin
        w_ins_val1  = issue_val1;
        w_ins_pend1 = issue_has_dep1;
        w_ins_val2  = issue_val2;
        w_ins_pend2 = issue_has_dep2;
        if (issue_has_dep1) begin
            if (alu_res && (alu_res_rob_pos == issue_dep1)) begin
                w_ins_val1  = alu_res_val;
                w_ins_pend1 = 1'b0;
            end else if (lsb_res && (lsb_res_rob_pos == issue_dep1)) begin
                w_ins_val1  = lsb_res_val;
                w_ins_pend1 = 1'b0;
            end
        end
        if (issue_has_dep2) begin
            if (alu_res && (alu_res_rob_pos == issue_dep2)) begin
                w_ins_val2  = alu_res_val;
                w_ins_pend2 = 1'b0;
            end else if (lsb_res && (lsb_res_rob_pos == issue_dep2)) begin
                w_ins_val2  = lsb_res_val;
                w_ins_pend2 = 1'b0;
            end
        end
    end

    always_comb begin
        w_busy_nxt = r_busy;
        if (rollback) begin
            w_busy_nxt = '0;
        end else begin
            if (w_sel_found) w_busy_nxt[w_sel_idx] = 1'b0;
            if (w_do_ins)    w_busy_nxt[w_ins_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy        <= '0;
            r_pend1       <= '0;
            r_pend2       <= '0;
            r_full        <= 1'b0;
            r_alu_en      <= 1'b0;
            r_alu_opcode  <= '0;
            r_alu_funct3  <= '0;
            r_alu_funct7  <= 1'b0;
            r_alu_val1    <= '0;
            r_alu_val2    <= '0;
            r_alu_imm     <= '0;
            r_alu_pc      <= '0;
            r_alu_rob_pos <= '0;
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                r_opcode[i]  <= '0;
                r_funct3[i]  <= '0;
                r_funct7[i]  <= 1'b0;
                r_val1[i]    <= '0;
                r_val2[i]    <= '0;
                r_tag1[i]    <= '0;
                r_tag2[i]    <= '0;
                r_imm[i]     <= '0;
                r_pc[i]      <= '0;
                r_rob_pos[i] <= '0;
            end
        end else if (rdy) begin
            r_busy <= w_busy_nxt;
            r_full <= &w_busy_nxt;
            if (rollback) begin
                r_alu_en <= 1'b0;
            end else begin
                r_alu_en <= w_sel_found;
                if (w_sel_found) begin
                    r_alu_opcode  <= r_opcode[w_sel_idx];
                    r_alu_funct3  <= r_funct3[w_sel_idx];
                    r_alu_funct7  <= r_funct7[w_sel_idx];
                    r_alu_val1    <= r_val1[w_sel_idx];
                    r_alu_val2    <= r_val2[w_sel_idx];
                    r_alu_imm     <= r_imm[w_sel_idx];
                    r_alu_pc      <= r_pc[w_sel_idx];
                    r_alu_rob_pos <= r_rob_pos[w_sel_idx];
                end
                // Wakeup: both buses snooped in parallel for every waiting operand
                for (int unsigned i = 0; i < RS_SIZE; i++) begin
                    if (r_busy[i] && r_pend1[i]) begin
                        if (alu_res && (alu_res_rob_pos == r_tag1[i])) begin
                            r_val1[i]  <= alu_res_val;
                            r_pend1[i] <= 1'b0;
                        end else if (lsb_res && (lsb_res_rob_pos == r_tag1[i])) begin
                            r_val1[i]  <= lsb_res_val;
                            r_pend1[i] <= 1'b0;
                        end
                    end
                    if (r_busy[i] && r_pend2[i]) begin
                        if (alu_res && (alu_res_rob_pos == r_tag2[i])) begin
                            r_val2[i]  <= alu_res_val;
                            r_pend2[i] <= 1'b0;
                        end else if (lsb_res && (lsb_res_rob_pos == r_tag2[i])) begin
                            r_val2[i]  <= lsb_res_val;
                            r_pend2[i] <= 1'b0;
                        end
                    end
                end
                if (w_do_ins) begin
                    r_opcode[w_ins_idx]  <= issue_opcode;
                    r_funct3[w_ins_idx]  <= issue_funct3;
                    r_funct7[w_ins_idx]  <= issue_funct7;
                    r_val1[w_ins_idx]    <= w_ins_val1;
                    r_val2[w_ins_idx]    <= w_ins_val2;
                    r_pend1[w_ins_idx]   <= w_ins_pend1;
                    r_pend2[w_ins_idx]   <= w_ins_pend2;
                    r_tag1[w_ins_idx]    <= issue_dep1;
                    r_tag2[w_ins_idx]    <= issue_dep2;
                    r_imm[w_ins_idx]     <= issue_imm;
                    r_pc[w_ins_idx]      <= issue_pc;
                    r_rob_pos[w_ins_idx] <= issue_rob_pos;
                end
            end
        end
    end

    assign rs_full     = r_full;
    assign alu_en      = r_alu_en;
    assign alu_opcode  = r_alu_opcode;
    assign alu_funct3  = r_alu_funct3;
    assign alu_funct7  = r_alu_funct7;
    assign alu_val1    = r_alu_val1;
    assign alu_val2    = r_alu_val2;
    assign alu_imm     = r_alu_imm;
    assign alu_pc      = r_alu_pc;
    assign alu_rob_pos = r_alu_rob_pos;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: dispatch latency, wakeup, bypass,
// full/drain ordering, slot reuse, rollback, freeze and asynchronous reset.
module tb_alu_reservation_station;

    import alu_reservation_station_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, rdy, rollback, issue;
    logic [3:0]  issue_rob_pos, issue_dep1, issue_dep2;
    logic [6:0]  issue_opcode;
    logic [2:0]  issue_funct3;
    logic        issue_funct7;
    logic [31:0] issue_val1, issue_val2, issue_imm, issue_pc;
    logic        issue_has_dep1, issue_has_dep2;
    logic        rs_full;
    logic        alu_res, lsb_res;
    logic [3:0]  alu_res_rob_pos, lsb_res_rob_pos;
    logic [31:0] alu_res_val, lsb_res_val;
    logic        alu_en;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_funct3;
    logic        alu_funct7;
    logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
    logic [3:0]  alu_rob_pos;

    int n_checks = 0;
    int n_fail   = 0;

    alu_reservation_station dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback),
        .issue(issue), .issue_rob_pos(issue_rob_pos), .issue_opcode(issue_opcode),
        .issue_funct3(issue_funct3), .issue_funct7(issue_funct7),
        .issue_val1(issue_val1), .issue_has_dep1(issue_has_dep1), .issue_dep1(issue_dep1),
        .issue_val2(issue_val2), .issue_has_dep2(issue_has_dep2), .issue_dep2(issue_dep2),
        .issue_imm(issue_imm), .issue_pc(issue_pc), .rs_full(rs_full),
        .alu_res(alu_res), .alu_res_rob_pos(alu_res_rob_pos), .alu_res_val(alu_res_val),
        .lsb_res(lsb_res), .lsb_res_rob_pos(lsb_res_rob_pos), .lsb_res_val(lsb_res_val),
        .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_funct3(alu_funct3),
        .alu_funct7(alu_funct7), .alu_val1(alu_val1), .alu_val2(alu_val2),
        .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        issue    = 1'b0;
        alu_res  = 1'b0;
        lsb_res  = 1'b0;
        rollback = 1'b0;
    endtask

    task automatic drive_issue(input logic [6:0] op, input logic [31:0] v1, input logic d1,
                               input logic [3:0] t1, input logic [31:0] v2, input logic d2,
                               input logic [3:0] t2, input logic [31:0] imm, input logic [3:0] rob);
        issue          = 1'b1;
        issue_opcode   = op;
        issue_funct3   = FUNCT3_ADD;
        issue_funct7   = 1'b0;
        issue_val1     = v1;
        issue_has_dep1 = d1;
        issue_dep1     = t1;
        issue_val2     = v2;
        issue_has_dep2 = d2;
        issue_dep2     = t2;
        issue_imm      = imm;
        issue_pc       = 32'h1000 + imm;
        issue_rob_pos  = rob;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rdy = 1'b1; idle();
        drive_issue(OPCODE_ARITH, 0, 0, 0, 0, 0, 0, 0, 0);
        issue = 1'b0;
        alu_res_rob_pos = 0; alu_res_val = 0; lsb_res_rob_pos = 0; lsb_res_val = 0;
        #1;
        if (alu_en !== 1'b0) begin $display("FAIL reset_en act=%0b exp=0", alu_en); n_fail++; end
        n_checks++;
        if (rs_full !== 1'b0) begin $display("FAIL reset_full act=%0b exp=0", rs_full); n_fail++; end
        n_checks++;
        tick(); tick();
        if ({alu_val1, alu_imm, alu_rob_pos, alu_opcode} !== '0) begin
            $display("FAIL reset_data act=%h/%h/%h/%h exp=0", alu_val1, alu_imm, alu_rob_pos, alu_opcode);
            n_fail++;
        end
        n_checks++;
        #2 rst_n = 1'b1;
        tick();
        if (alu_en !== 1'b0) begin $display("FAIL reset_post_en act=%0b exp=0", alu_en); n_fail++; end
        n_checks++;
    endtask

    task automatic test_issue_ready;
        drive_issue(OPCODE_ARITHI, 32'd5, 0, 0, 32'd0, 0, 0, 32'd3, 4'd2);
        tick(); idle();
        if (alu_en !== 1'b0) begin $display("FAIL t1_early_en act=%0b exp=0", alu_en); n_fail++; end
        n_checks++;
        tick();
        if (alu_en !== 1'b1 || alu_opcode !== OPCODE_ARITHI || alu_val1 !== 32'd5 ||
            alu_imm !== 32'd3 || alu_rob_pos !== 4'd2 || alu_pc !== 32'h1003) begin
            $display("FAIL t1_dispatch act=en%0b op%h v1=%h imm=%h rob=%0d pc=%h exp=en1 op13 v1=5 imm=3 rob=2 pc=1003",
                     alu_en, alu_opcode, alu_val1, alu_imm, alu_rob_pos, alu_pc);
            n_fail++;
        end
        n_checks++;
        tick();
        if (alu_en !== 1'b0) begin $display("FAIL t1_pulse_end act=%0b exp=0", alu_en); n_fail++; end
        n_checks++;
    endtask

    task automatic test_wakeup;
        drive_issue(OPCODE_ARITH, 32'd0, 1, 4'd7, 32'd1, 0, 0, 32'd0, 4'd5);
        tick(); idle();
        for (int k = 0; k < 3; k++) begin
            if (alu_en !== 1'b0) begin $display("FAIL t2_wait_en%0d act=%0b exp=0", k, alu_en); n_fail++; end
            n_checks++;
            tick();
        end
        alu_res = 1'b1; alu_res_rob_pos = 4'd7; alu_res_val = 32'h10;
        tick(); idle();
        if (alu_en !== 1'b0) begin $display("FAIL t2_wake_cycle_en act=%0b exp=0", alu_en); n_fail++; end
        n_checks++;
        tick();
        if (alu_en !== 1'b1 || alu_val1 !== 32'h10 || alu_val2 !== 32'd1 || alu_rob_pos !== 4'd5) begin
            $display("FAIL t2_dispatch act=en%0b v1=%h v2=%h rob=%0d exp=en1 v1=10 v2=1 rob=5",
                     alu_en, alu_val1, alu_val2, alu_rob_pos);
            n_fail++;
        end
        n_checks++;
        tick();
    endtask

    task automatic test_bypass;
        drive_issue(OPCODE_BR, 32'd7, 0, 0, 32'd0, 1, 4'd4, 32'd8, 4'd6);
        lsb_res = 1'b1; lsb_res_rob_pos = 4'd4; lsb_res_val = 32'hABCD;
        alu_res = 1'b1; alu_res_rob_pos = 4'd5; alu_res_val = 32'h1111;
        tick(); idle();
        if (alu_en !== 1'b0) begin $display("FAIL t3_early_en act=%0b exp=0", alu_en); n_fail++; end
        n_checks++;
        tick();
        if (alu_en !== 1'b1 || alu_val1 !== 32'd7 || alu_val2 !== 32'hABCD || alu_opcode !== OPCODE_BR) begin
            $display("FAIL t3_dispatch act=en%0b v1=%h v2=%h op=%h exp=en1 v1=7 v2=abcd op=63",
                     alu_en, alu_val1, alu_val2, alu_opcode);
            n_fail++;
        end
        n_checks++;
        tick();
    endtask

    task automatic test_dual_wakeup;
        drive_issue(OPCODE_ARITH, 32'd0, 1, 4'd1, 32'd0, 1, 4'd2, 32'h20, 4'd8);
        tick(); idle();
        alu_res = 1'b1; alu_res_rob_pos = 4'd2; alu_res_val = 32'h2222;
        lsb_res = 1'b1; lsb_res_rob_pos = 4'd1; lsb_res_val = 32'h1111;
        tick(); idle();
        tick();
        if (alu_en !== 1'b1 || alu_val1 !== 32'h1111 || alu_val2 !== 32'h2222) begin
            $display("FAIL dual_wake act=en%0b v1=%h v2=%h exp=en1 v1=1111 v2=2222", alu_en, alu_val1, alu_val2);
            n_fail++;
        end
        n_checks++;
        tick();
    endtask

    task automatic test_full;
        for (int i = 0; i < 16; i++) begin
            drive_issue(OPCODE_ARITH, 32'd0, 1, 4'd9, 32'd0, 0, 0, 32'(i), 4'(i));
            tick();
            if (i == 14) begin
                if (rs_full !== 1'b0) begin $display("FAIL full_at15 act=%0b exp=0", rs_full); n_fail++; end
                n_checks++;
            end
        end
        idle();
        if (rs_full !== 1'b1 || alu_en !== 1'b0) begin
            $display("FAIL full_at16 act=full%0b en%0b exp=full1 en0", rs_full, alu_en); n_fail++;
        end
        n_checks++;
        alu_res = 1'b1; alu_res_rob_pos = 4'd9; alu_res_val = 32'h900;
        tick(); idle();
        for (int i = 0; i < 16; i++) begin
            tick();
            if (alu_en !== 1'b1 || alu_imm !== 32'(i) || alu_rob_pos !== 4'(i) || alu_val1 !== 32'h900) begin
                $display("FAIL drain_%0d act=en%0b imm=%0d rob=%0d v1=%h exp=en1 imm=%0d rob=%0d v1=900",
                         i, alu_en, alu_imm, alu_rob_pos, alu_val1, i, i);
                n_fail++;
            end
            n_checks++;
            if (i == 0) begin
                if (rs_full !== 1'b0) begin $display("FAIL full_drop act=%0b exp=0", rs_full); n_fail++; end
                n_checks++;
            end
        end
        tick();
        if (alu_en !== 1'b0) begin $display("FAIL drain_end act=%0b exp=0", alu_en); n_fail++; end
        n_checks++;
    endtask

    task automatic test_back_to_back;
        drive_issue(OPCODE_ARITHI, 32'd1, 0, 0, 32'd0, 0, 0, 32'hA1, 4'd1);
        tick();
        drive_issue(OPCODE_ARITH, 32'd0, 1, 4'd12, 32'd0, 0, 0, 32'hB2, 4'd2);
        tick();
        if (alu_en !== 1'b1 || alu_imm !== 32'hA1) begin
            $display("FAIL b2b_first act=en%0b imm=%h exp=en1 imm=a1", alu_en, alu_imm); n_fail++;
        end
        n_checks++;
        drive_issue(OPCODE_ARITH, 32'd0, 1, 4'd13, 32'd0, 0, 0, 32'hC3, 4'd3);
        tick(); idle();
        alu_res = 1'b1; alu_res_rob_pos = 4'd13; alu_res_val = 32'h13;
        lsb_res = 1'b1; lsb_res_rob_pos = 4'd12; lsb_res_val = 32'h12;
        tick(); idle();
        tick();
        if (alu_en !== 1'b1 || alu_imm !== 32'hB2 || alu_val1 !== 32'h12) begin
            $display("FAIL b2b_slot0 act=en%0b imm=%h v1=%h exp=en1 imm=b2 v1=12", alu_en, alu_imm, alu_val1);
            n_fail++;
        end
        n_checks++;
        tick();
        if (alu_en !== 1'b1 || alu_imm !== 32'hC3 || alu_val1 !== 32'h13) begin
            $display("FAIL b2b_slot1 act=en%0b imm=%h v1=%h exp=en1 imm=c3 v1=13", alu_en, alu_imm, alu_val1);
            n_fail++;
        end
        n_checks++;
        tick();
    endtask

    task automatic test_rollback;
        for (int i = 0; i < 5; i++) begin
            drive_issue(OPCODE_ARITH, 32'd0, 1, 4'd3, 32'd0, 0, 0, 32'(i), 4'(i));
            tick();
        end
        idle();
        alu_res = 1'b1; alu_res_rob_pos = 4'd3; alu_res_val = 32'h3;
        tick(); idle();
        rollback = 1'b1;
        drive_issue(OPCODE_ARITHI, 32'd9, 0, 0, 32'd0, 0, 0, 32'h55, 4'd9);
        alu_res = 1'b1; alu_res_rob_pos = 4'd3;
        tick(); idle();
        if (alu_en !== 1'b0 || rs_full !== 1'b0) begin
            $display("FAIL rollback_flush act=en%0b full%0b exp=en0 full0", alu_en, rs_full); n_fail++;
        end
        n_checks++;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (alu_en !== 1'b0) begin $display("FAIL rollback_quiet%0d act=%0b exp=0", k, alu_en); n_fail++; end
            n_checks++;
        end
    endtask

    task automatic test_freeze_reset;
        for (int i = 0; i < 4; i++) begin
            drive_issue(OPCODE_LUI, 32'd0, 1, 4'd5, 32'd0, 0, 0, 32'h40 + 32'(i), 4'(i));
            tick();
        end
        idle();
        alu_res = 1'b1; alu_res_rob_pos = 4'd5; alu_res_val = 32'h5;
        tick(); idle();
        tick();
        if (alu_en !== 1'b1 || alu_imm !== 32'h40) begin
            $display("FAIL freeze_pre act=en%0b imm=%h exp=en1 imm=40", alu_en, alu_imm); n_fail++;
        end
        n_checks++;
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (alu_en !== 1'b1 || alu_imm !== 32'h40) begin
                $display("FAIL freeze_hold%0d act=en%0b imm=%h exp=en1 imm=40", k, alu_en, alu_imm); n_fail++;
            end
            n_checks++;
        end
        rdy = 1'b1;
        tick();
        if (alu_en !== 1'b1 || alu_imm !== 32'h41) begin
            $display("FAIL freeze_resume act=en%0b imm=%h exp=en1 imm=41", alu_en, alu_imm); n_fail++;
        end
        n_checks++;
        #2 rst_n = 1'b0;
        #1;
        if (alu_en !== 1'b0 || alu_imm !== 32'd0 || rs_full !== 1'b0) begin
            $display("FAIL async_reset act=en%0b imm=%h full%0b exp=en0 imm=0 full0", alu_en, alu_imm, rs_full);
            n_fail++;
        end
        n_checks++;
        tick(); tick();
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (alu_en !== 1'b0) begin $display("FAIL post_reset_quiet%0d act=%0b exp=0", k, alu_en); n_fail++; end
            n_checks++;
        end
    endtask

    initial begin
        test_reset();
        test_issue_ready();
        test_wakeup();
        test_bypass();
        test_dual_wakeup();
        test_full();
        test_back_to_back();
        test_rollback();
        test_freeze_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
